sseg_scan_ctrl: RTL

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_scan_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment display scanner.
// Scans NUM_DIGITS digits one slot at a time, blanks the anodes for a short
// dead time at the start of every slot to stop ghosting, dims digits with a
// 16-step PWM, and double-buffers the display contents so that a new picture
// only takes effect at a frame boundary.
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int SLOT_CYCLES    = 65536,
    parameter int DEAD_CYCLES    = 64,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [7:0]            data_i [0:NUM_DIGITS-1],
    input  logic [NUM_DIGITS-1:0] digit_en_i,
    input  logic [3:0]            bright_i,
    input  logic                  load_i,
    output logic [NUM_DIGITS-1:0] anode_o,
    output logic [7:0]            sseg_o,
    output logic                  frame_o
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_C    = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Map a set of logically-lit anodes to pin levels.
    function automatic logic [NUM_DIGITS-1:0] anode_drive(input logic [NUM_DIGITS-1:0] lit);
        return AN_ACTIVE_LOW ? ~lit : lit;
    endfunction

    // Map a stored segment pattern (1 = lit) to pin levels.
    function automatic logic [7:0] seg_drive(input logic [7:0] pat);
        return SEG_ACTIVE_LOW ? ~pat : pat;
    endfunction

    // Scan state
    logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            pwm_q, pwm_d;

    // Double-buffered display contents
    logic                  pending_q, pending_d;
    logic [7:0]            stg_data_q [0:NUM_DIGITS-1];
    logic [7:0]            stg_data_d [0:NUM_DIGITS-1];
    logic [NUM_DIGITS-1:0] stg_en_q, stg_en_d;
    logic [3:0]            stg_bright_q, stg_bright_d;
    logic [7:0]            act_data_q [0:NUM_DIGITS-1];
    logic [7:0]            act_data_d [0:NUM_DIGITS-1];
    logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
    logic [3:0]            act_bright_q, act_bright_d;

    // Output registers
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [7:0]            sseg_q, sseg_d;
    logic                  frame_q, frame_d;

    logic                  slot_wrap;
    logic                  frame_wrap;
    logic                  in_dead;
    logic [3:0]            pwm_cur;
    logic [NUM_DIGITS-1:0] lit;

    // The dead-time comparison only exists when there is a dead time at all.
    if (DEAD_CYCLES > 0) begin : g_dead
        assign in_dead = (slot_cnt_q < DEAD_C);
    end else begin : g_no_dead
        assign in_dead = 1'b0;
    end

    // Slot counter, digit index and PWM sequencing.
    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        frame_wrap = slot_wrap && (idx_q == IDX_LAST);
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        // The PWM phase restarts on the first lit-capable cycle of every slot,
        // so each digit sees the same duty pattern regardless of history.
        pwm_cur = (slot_cnt_q == DEAD_C) ? 4'd0 : pwm_q;
        pwm_d   = in_dead ? pwm_q : pwm_cur + 4'd1;
    end

    // Staging capture on load, transfer to the active set only at a frame wrap.
    always_comb begin
        pending_d    = pending_q;
        stg_en_d     = stg_en_q;
        stg_bright_d = stg_bright_q;
        act_en_d     = act_en_q;
        act_bright_d = act_bright_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            stg_data_d[i] = stg_data_q[i];
            act_data_d[i] = act_data_q[i];
        end
        if (load_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stg_data_d[i] = data_i[i];
            end
            stg_en_d     = digit_en_i;
            stg_bright_d = bright_i;
            pending_d    = 1'b1;
        end
        // A load on the wrap cycle itself bypasses staging so it shows at once.
        if (frame_wrap && (pending_q || load_i)) begin
            if (load_i) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    act_data_d[i] = data_i[i];
                end
                act_en_d     = digit_en_i;
                act_bright_d = bright_i;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    act_data_d[i] = stg_data_q[i];
                end
                act_en_d     = stg_en_q;
                act_bright_d = stg_bright_q;
            end
            pending_d = 1'b0;
        end
    end

    // Next pin values, derived from the current scan state and active set.
    always_comb begin
        lit = '0;
        if (!in_dead && act_en_q[idx_q] && (pwm_cur <= act_bright_q)) begin
            lit[idx_q] = 1'b1;
        end
        anode_d = anode_drive(lit);
        sseg_d  = seg_drive(act_data_q[idx_q]);
        frame_d = (slot_cnt_q == '0) && (idx_q == '0);
    end

    // Scan state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
            pwm_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            pwm_q      <= pwm_d;
        end
    end

    // Staging and active display registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q    <= 1'b0;
            stg_en_q     <= '0;
            stg_bright_q <= '0;
            act_en_q     <= '0;
            act_bright_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stg_data_q[i] <= '0;
                act_data_q[i] <= '0;
            end
        end else begin
            pending_q    <= pending_d;
            stg_en_q     <= stg_en_d;
            stg_bright_q <= stg_bright_d;
            act_en_q     <= act_en_d;
            act_bright_q <= act_bright_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stg_data_q[i] <= stg_data_d[i];
                act_data_q[i] <= act_data_d[i];
            end
        end
    end

    // Output pin registers; reset forces a dark display immediately.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            anode_q <= anode_drive('0);
            sseg_q  <= seg_drive(8'h00);
            frame_q <= 1'b0;
        end else begin
            anode_q <= anode_d;
            sseg_q  <= sseg_d;
            frame_q <= frame_d;
        end
    end

    assign anode_o = anode_q;
    assign sseg_o  = sseg_q;
    assign frame_o = frame_q;

endmodule
